// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and default widths for the instruction fetch front end
package fetch_pkg;

    localparam int FETCH_PC_W = 10;
    localparam int FETCH_INSTR_W = 9;
    localparam logic [FETCH_INSTR_W-1:0] FETCH_HALT_INSTR = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_PC_W-1:0]    pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular prefetch buffer with synchronous flush and occupancy count
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = $bits(fetch_entry_t)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;

    // Flush wins over any same-cycle push or pop.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wr_d = wr_q + AW'(1);
            if (pop)  rd_d = rd_q + AW'(1);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + (AW+1)'(1);
                2'b01:   cnt_d = cnt_q - (AW+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_q] <= wdata;
    end

    assign rdata = mem_q[rd_q];
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC, ROM issue with credit control, redirect and halt handling
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                  PC_W       = FETCH_PC_W,
    parameter int                  INSTR_W    = FETCH_INSTR_W,
    parameter int                  DEPTH      = 2,
    parameter logic [PC_W-1:0]     RESET_PC   = '0,
    parameter logic [INSTR_W-1:0]  HALT_INSTR = INSTR_W'(FETCH_HALT_INSTR)
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               run,
    output logic               rom_rd_en,
    output logic [PC_W-1:0]    rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               halt
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  infl_pc_q;
    logic             infl_q;

    logic [CW-1:0]            fifo_count;
    logic                     fifo_empty;
    logic [PC_W+INSTR_W-1:0]  head;
    logic [CW:0]              demand;
    logic running, pop, push, flush, halt_pop, issue;

    assign running     = (state_q == RUN);
    assign instr_valid = running & ~fifo_empty;
    assign pop         = instr_valid & instr_ready;
    assign halt_pop    = pop & (head[INSTR_W-1:0] == HALT_INSTR);
    assign flush       = running & (redirect_valid | halt_pop);
    assign push        = running & infl_q & ~flush;

    // Entries held plus the one in flight, less the one leaving this cycle, must leave room.
    assign demand = {1'b0, fifo_count} + (CW+1)'(infl_q) - (CW+1)'(pop);
    assign issue  = running & run & ~redirect_valid & (demand < (CW+1)'(DEPTH));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                if (run) state_d = RUN;
            end
            RUN: begin
                if (halt_pop) state_d = HALTED;
                if (redirect_valid)
                    pc_d = redirect_pc;
                else if (issue)
                    pc_d = pc_q + PC_W'(1);
            end
            HALTED: state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            infl_q    <= 1'b0;
            infl_pc_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            infl_q  <= issue;
            if (issue) infl_pc_q <= pc_q;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PC_W + INSTR_W)
    ) u_fifo (
        .clk   (CLK),
        .rst   (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata ({infl_pc_q, rom_data}),
        .rdata (head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rom_rd_en = issue;
    assign rom_addr  = pc_q;
    assign instr     = instr_valid ? head[INSTR_W-1:0] : '0;
    assign instr_pc  = instr_valid ? head[PC_W+INSTR_W-1:INSTR_W] : '0;
    assign halt      = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic       CLK = 1'b0;
    logic       reset;
    logic       run;
    logic       instr_ready;
    logic       redirect_valid;
    logic [9:0] redirect_pc;
    logic       halt_mode;

    logic       rom_rd_en, instr_valid, halt;
    logic [9:0] rom_addr, instr_pc;
    logic [8:0] rom_data, instr;

    logic       u2_rom_rd_en, u2_instr_valid, u2_halt;
    logic [9:0] u2_rom_addr, u2_instr_pc;
    logic [8:0] u2_rom_data, u2_instr;
    logic       u2_ready = 1'b1;
    logic       u2_redir = 1'b0;
    logic [9:0] u2_redir_pc = 10'h000;

    int n_chk = 0;
    int n_err = 0;
    int exp_pc;

    always #5 CLK = ~CLK;

    fetch_unit u_dut (
        .CLK            (CLK),
        .reset          (reset),
        .run            (run),
        .rom_rd_en      (rom_rd_en),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .halt           (halt)
    );

    fetch_unit #(.RESET_PC(10'h3FE)) u_wrap (
        .CLK            (CLK),
        .reset          (reset),
        .run            (run),
        .rom_rd_en      (u2_rom_rd_en),
        .rom_addr       (u2_rom_addr),
        .rom_data       (u2_rom_data),
        .redirect_valid (u2_redir),
        .redirect_pc    (u2_redir_pc),
        .instr_valid    (u2_instr_valid),
        .instr_ready    (u2_ready),
        .instr          (u2_instr),
        .instr_pc       (u2_instr_pc),
        .halt           (u2_halt)
    );

    function automatic logic [8:0] rom_f(input logic [9:0] a, input logic hm);
        if (hm && a == 10'd5) return 9'h1FF;
        return a[8:0] + 9'h010;
    endfunction

    always @(posedge CLK) begin
        if (rom_rd_en)    rom_data    <= rom_f(rom_addr, halt_mode);
        if (u2_rom_rd_en) u2_rom_data <= rom_f(u2_rom_addr, 1'b0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [9:0] wpc;
        reset = 1'b1; run = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 10'h000; halt_mode = 1'b0;
        #3;
        chk("rst_rd_en",    32'(rom_rd_en),   0);
        chk("rst_addr",     32'(rom_addr),    0);
        chk("rst_valid",    32'(instr_valid), 0);
        chk("rst_instr",    32'(instr),       0);
        chk("rst_pc",       32'(instr_pc),    0);
        chk("rst_halt",     32'(halt),        0);
        chk("rst_wrap_addr", 32'(u2_rom_addr), 32'h3FE);

        step; step;
        reset = 1'b0; run = 1'b1; instr_ready = 1'b1;
        #1;
        chk("idle_rd_en", 32'(rom_rd_en), 0);
        step;
        chk("first_rd_en", 32'(rom_rd_en), 1);
        chk("first_addr",  32'(rom_addr),  0);
        step;
        chk("second_addr",  32'(rom_addr),    1);
        chk("second_valid", 32'(instr_valid), 0);
        step;

        // free run with the wrap instance checked alongside
        exp_pc = 0;
        for (int i = 0; i < 6; i++) begin
            chk("run_valid", 32'(instr_valid), 1);
            chk("run_pc",    32'(instr_pc),    32'(exp_pc));
            chk("run_instr", 32'(instr),       32'(rom_f(10'(exp_pc), 1'b0)));
            chk("run_addr",  32'(rom_addr),    32'(exp_pc + 2));
            chk("run_rd_en", 32'(rom_rd_en),   1);
            wpc = 10'h3FE + 10'(i);
            chk("wrap_valid", 32'(u2_instr_valid), 1);
            chk("wrap_pc",    32'(u2_instr_pc),    32'(wpc));
            chk("wrap_instr", 32'(u2_instr),       32'(rom_f(wpc, 1'b0)));
            step;
            exp_pc++;
        end

        // backpressure
        instr_ready = 1'b0;
        #1;
        chk("bp_rd_en_drop", 32'(rom_rd_en), 0);
        for (int i = 0; i < 6; i++) begin
            chk("bp_valid", 32'(instr_valid), 1);
            chk("bp_pc",    32'(instr_pc),    32'(exp_pc));
            chk("bp_rd_en", 32'(rom_rd_en),   0);
            step;
        end
        instr_ready = 1'b1;
        #1;
        chk("bp_resume_rd_en", 32'(rom_rd_en), 1);
        chk("bp_resume_addr",  32'(rom_addr),  32'(exp_pc + 2));
        for (int i = 0; i < 5; i++) begin
            chk("bp_cont_valid", 32'(instr_valid), 1);
            chk("bp_cont_pc",    32'(instr_pc),    32'(exp_pc));
            chk("bp_cont_instr", 32'(instr),       32'(rom_f(10'(exp_pc), 1'b0)));
            step;
            exp_pc++;
        end

        // redirect with one entry queued and one read in flight
        instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 10'h200;
        #1;
        chk("redir_rd_en", 32'(rom_rd_en), 0);
        step;
        redirect_valid = 1'b0; instr_ready = 1'b1;
        #1;
        chk("redir_flush_valid", 32'(instr_valid), 0);
        chk("redir_flush_instr", 32'(instr),       0);
        chk("redir_flush_pc",    32'(instr_pc),    0);
        chk("redir_rd_en_back",  32'(rom_rd_en),   1);
        chk("redir_addr",        32'(rom_addr),    32'h200);
        step;
        chk("redir_gap_valid", 32'(instr_valid), 0);
        chk("redir_addr2",     32'(rom_addr),    32'h201);
        step;
        chk("redir_head_valid", 32'(instr_valid), 1);
        chk("redir_head_pc",    32'(instr_pc),    32'h200);
        chk("redir_head_instr", 32'(instr),       32'(rom_f(10'h200, 1'b0)));
        step;
        chk("redir_next_pc",    32'(instr_pc),    32'h201);

        // reset between edges while the queue holds entries
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_rd_en", 32'(rom_rd_en),   0);
        chk("mid_rst_addr",  32'(rom_addr),    0);
        chk("mid_rst_valid", 32'(instr_valid), 0);
        chk("mid_rst_instr", 32'(instr),       0);
        chk("mid_rst_pc",    32'(instr_pc),    0);
        chk("mid_rst_halt",  32'(halt),        0);
        halt_mode = 1'b1;
        step;
        reset = 1'b0;
        step;
        chk("restart_rd_en", 32'(rom_rd_en), 1);
        chk("restart_addr",  32'(rom_addr),  0);
        step; step;

        // halt instruction at PC 5
        exp_pc = 0;
        for (int i = 0; i < 5; i++) begin
            chk("pre_halt_pc",    32'(instr_pc), 32'(exp_pc));
            chk("pre_halt_instr", 32'(instr),    32'(rom_f(10'(exp_pc), 1'b1)));
            step;
            exp_pc++;
        end
        chk("halt_head_pc",    32'(instr_pc), 5);
        chk("halt_head_instr", 32'(instr),    32'h1FF);
        chk("halt_not_yet",    32'(halt),     0);
        chk("halt_pop_addr",   32'(rom_addr), 7);
        step;
        chk("halt_set",       32'(halt),        1);
        chk("halt_rd_en",     32'(rom_rd_en),   0);
        chk("halt_valid",     32'(instr_valid), 0);
        chk("halt_instr",     32'(instr),       0);
        redirect_valid = 1'b1; redirect_pc = 10'h100;
        step; step;
        redirect_valid = 1'b0;
        #1;
        chk("halt_redir_ignored_addr", 32'(rom_addr),    8);
        chk("halt_sticky",             32'(halt),        1);
        chk("halt_sticky_rd_en",       32'(rom_rd_en),   0);
        chk("halt_sticky_valid",       32'(instr_valid), 0);
        step; step; step;
        chk("halt_late",       32'(halt),      1);
        chk("halt_late_rd_en", 32'(rom_rd_en), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
